// File: rtl/datamem_lsu.sv
// rtl/datamem_lsu.sv - MEM-stage load/store unit with byte-lane placement and configurable read latency
// Owns its word array; single outstanding access with valid/ready request and response handshakes.
module datamem_lsu #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int WORDS = 1 << (DM_ADDRESS - 2);

  if (DATA_W != 32) begin : g_bad_width
    $error("datamem_lsu: DATA_W must be 32");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("datamem_lsu: RD_LATENCY must be in 1..4");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state;
  logic [1:0]          cnt;
  logic [DATA_W-1:0]   load_q;
  logic [DATA_W-1:0]   mem [WORDS];

  logic                accept;
  logic [DM_ADDRESS-3:0] idx;
  logic [1:0]          off;
  logic                acc_err;
  logic [3:0]          be;
  logic [DATA_W-1:0]   wword;
  logic [DATA_W-1:0]   rword;
  logic [7:0]          rbyte;
  logic [15:0]         rhalf;
  logic [DATA_W-1:0]   ldata;

  assign accept = req_valid && req_ready;
  assign idx    = req_addr[DM_ADDRESS-1:2];
  assign off    = req_addr[1:0];
  assign rword  = mem[idx];
  assign rbyte  = rword[{off, 3'b000} +: 8];
  assign rhalf  = rword[{off[1], 4'b0000} +: 16];

  // Decode lanes, extraction and legality for the request currently presented.
  always_comb begin
    acc_err = 1'b0;
    be      = 4'b0000;
    wword   = req_wdata;
    ldata   = '0;
    if (req_we) begin
      case (req_funct3)
        3'b000: begin
          be    = 4'b0001 << off;
          wword = {4{req_wdata[7:0]}};
        end
        3'b001: begin
          be      = off[1] ? 4'b1100 : 4'b0011;
          wword   = {2{req_wdata[15:0]}};
          acc_err = off[0];
        end
        3'b010: begin
          be      = 4'b1111;
          acc_err = (off != 2'b00);
        end
        default: acc_err = 1'b1;
      endcase
      if (acc_err) be = 4'b0000;
    end else begin
      case (req_funct3)
        3'b000: ldata = {{24{rbyte[7]}}, rbyte};
        3'b100: ldata = {24'h0, rbyte};
        3'b001: begin
          ldata   = {{16{rhalf[15]}}, rhalf};
          acc_err = off[0];
        end
        3'b101: begin
          ldata   = {16'h0, rhalf};
          acc_err = off[0];
        end
        3'b010: begin
          ldata   = rword;
          acc_err = (off != 2'b00);
        end
        default: acc_err = 1'b1;
      endcase
      if (acc_err) ldata = '0;
    end
  end

  // Array writes happen only on the accept edge, so a reset can never leave a store half-applied.
  always_ff @(posedge clk) begin
    if (accept && req_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 2'd0;
      load_q    <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (!req_we && !acc_err) begin
              state  <= S_WAIT;
              cnt    <= 2'(RD_LATENCY - 1);
              load_q <= ldata;
            end else begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= acc_err;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 2'd0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_q;
            rsp_err   <= 1'b0;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datamem_lsu.sv
// tb/tb_datamem_lsu.sv - directed self-checking bench for datamem_lsu
// Two instances (RD_LATENCY 1 and 4) share stimulus; sel picks which one sees req_valid.
module tb_datamem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_ready;

  logic        rr1, rv1, re1, rr4, rv4, re4;
  logic [31:0] rd1, rd4;
  logic        rr, rv, re;
  logic [31:0] rd;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int edges;

  always #5 clk = ~clk;

  datamem_lsu #(.DM_ADDRESS(9), .DATA_W(32), .RD_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !sel), .req_ready(rr1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(re1)
  );

  datamem_lsu #(.DM_ADDRESS(9), .DATA_W(32), .RD_LATENCY(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel), .req_ready(rr4),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rv4), .rsp_ready(rsp_ready), .rsp_rdata(rd4), .rsp_err(re4)
  );

  assign rr = sel ? rr4 : rr1;
  assign rv = sel ? rv4 : rv1;
  assign rd = sel ? rd4 : rd1;
  assign re = sel ? re4 : re1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request, returns edges from accept (accept edge = 1) until rsp_valid is seen.
  task automatic issue(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, output int n);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (rv !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic xact(input string tag, input logic we, input logic [8:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3,
                      input logic [31:0] exp_data, input logic exp_err, input int exp_edges);
    int n;
    issue(we, addr, wdata, f3, n);
    check({tag, " latency"}, 32'(n), 32'(exp_edges));
    check({tag, " rdata"}, rd, exp_data);
    check({tag, " err"}, {31'h0, re}, {31'h0, exp_err});
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", {31'h0, rr}, 32'd1);
    check("reset rsp_valid", {31'h0, rv}, 32'd0);
    check("reset rsp_rdata", rd, 32'h0);
    check("reset rsp_err", {31'h0, re}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    xact("sw 010", 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 1);
    xact("lw 010", 1'b0, 9'h010, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 2);

    xact("sb 011", 1'b1, 9'h011, 32'h0000007F, 3'b000, 32'h0, 1'b0, 1);
    xact("lb 011", 1'b0, 9'h011, 32'h0, 3'b000, 32'h0000007F, 1'b0, 2);
    xact("lbu 013", 1'b0, 9'h013, 32'h0, 3'b100, 32'h000000DE, 1'b0, 2);
    xact("lw 010 after sb", 1'b0, 9'h010, 32'h0, 3'b010, 32'hDEAD7FEF, 1'b0, 2);
    xact("lb 012", 1'b0, 9'h012, 32'h0, 3'b000, 32'hFFFFFFAD, 1'b0, 2);

    xact("sw 020", 1'b1, 9'h020, 32'h12345678, 3'b010, 32'h0, 1'b0, 1);
    xact("sh 022", 1'b1, 9'h022, 32'h00008001, 3'b001, 32'h0, 1'b0, 1);
    xact("lh 022", 1'b0, 9'h022, 32'h0, 3'b001, 32'hFFFF8001, 1'b0, 2);
    xact("lhu 022", 1'b0, 9'h022, 32'h0, 3'b101, 32'h00008001, 1'b0, 2);
    xact("lw 020", 1'b0, 9'h020, 32'h0, 3'b010, 32'h80015678, 1'b0, 2);

    xact("sw 030", 1'b1, 9'h030, 32'h11223344, 3'b010, 32'h0, 1'b0, 1);
    xact("sw misaligned 031", 1'b1, 9'h031, 32'hFFFFFFFF, 3'b010, 32'h0, 1'b1, 1);
    xact("lh misaligned 033", 1'b0, 9'h033, 32'h0, 3'b001, 32'h0, 1'b1, 1);
    xact("load f3 011", 1'b0, 9'h030, 32'h0, 3'b011, 32'h0, 1'b1, 1);
    xact("store f3 100", 1'b1, 9'h030, 32'hAAAAAAAA, 3'b100, 32'h0, 1'b1, 1);
    xact("lw 030 intact", 1'b0, 9'h030, 32'h0, 3'b010, 32'h11223344, 1'b0, 2);

    rsp_ready = 1'b0;
    issue(1'b0, 9'h010, 32'h0, 3'b010, edges);
    check("hold latency", 32'(edges), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("hold rsp_valid", {31'h0, rv}, 32'd1);
      check("hold rsp_rdata", rd, 32'hDEAD7FEF);
      check("hold rsp_err", {31'h0, re}, 32'd0);
      check("hold req_ready", {31'h0, rr}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("release rsp_valid", {31'h0, rv}, 32'd0);
    check("release req_ready", {31'h0, rr}, 32'd1);

    sel = 1'b1;
    xact("lat4 sw 010", 1'b1, 9'h010, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, 1);
    xact("lat4 lw 010", 1'b0, 9'h010, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, 5);

    req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h010; req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("wait req_ready", {31'h0, rr}, 32'd0);
    check("wait rsp_valid", {31'h0, rv}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async reset req_ready", {31'h0, rr}, 32'd1);
    check("async reset rsp_valid", {31'h0, rv}, 32'd0);
    check("async reset rsp_rdata", rd, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("aborted load no rsp", {31'h0, rv}, 32'd0);
    end
    check("after abort req_ready", {31'h0, rr}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
